mips_cpu_ram_avalon_wait: RTL and testbench

//  Simulation memory model for the MIPS CPU testbench. Word-addressed Avalon-MM slave with byte enables.

---
 rtl/mips_cpu_ram_pkg.sv | 17 +
 rtl/mips_cpu_ram_avalon_wait_if.sv | 23 ++
 rtl/mips_cpu_ram_lfsr.sv | 23 ++
 rtl/mips_cpu_ram_avalon_wait.sv | 158 +++++++++++++++
 tb/tb_mips_cpu_ram_avalon_wait.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_ram_pkg.sv
// Shared types and helpers for the MIPS CPU Avalon-MM simulation RAM.
package mips_cpu_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } ram_state_t;

    localparam logic [31:0] HALT_ADDR = 32'h0;

    // Expand the four lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mips_cpu_ram_avalon_wait_if.sv
// Avalon-MM bus between the CPU (master) and the simulation RAM (slave).
interface mips_cpu_ram_avalon_wait_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, bus_error
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, bus_error
    );

endinterface

// File: rtl/mips_cpu_ram_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per advance pulse.
module mips_cpu_ram_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/mips_cpu_ram_avalon_wait.sv
// Word-addressed Avalon-MM simulation RAM with wait states, byte enables and bus error.
// Define RAM_RANDOM_WAIT_EN to draw each transfer's wait count from an LFSR.
//
// state | meaning
// IDLE  | waiting for read/write; request fields latched on acceptance
// WAIT  | counting down wait states, waitrequest high
// ACK   | transfer completes, waitrequest low for one cycle
module mips_cpu_ram_avalon_wait
    import mips_cpu_ram_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
    parameter int          DEPTH_WORDS   = 65536,
    parameter int          WAIT_CYCLES   = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic                      clk,
    input logic                      reset,
    mips_cpu_ram_avalon_wait_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_ACK  = ACK;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (LFSR_SEED == 16'h0) begin : g_seed_chk
        $error("LFSR_SEED must be non-zero");
    end

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [29:0] lat_addr;
    logic        lat_wr;
    logic [31:0] lat_wd;
    logic [3:0]  lat_be;
    logic [31:0] rdata_q;
    logic        berr_q;

    logic        req;
    logic        accept;
    logic        go_ack;
    logic [3:0]  wait_val;
    logic [29:0] a_addr;
    logic [3:0]  a_be;
    logic [29:0] word_idx;
    logic        is_halt;
    logic        in_range;
    logic [31:0] mem_word;
    logic [31:0] mask;

    assign req    = bus.read | bus.write;
    assign accept = (state == ST_IDLE) && req;

`ifdef RAM_RANDOM_WAIT_EN
    logic [15:0] lfsr_val;

    mips_cpu_ram_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_val)
    );

    assign wait_val = 4'({1'b0, lfsr_val[3:0]} % 5'(WAIT_CYCLES + 1));
`else
    assign wait_val = 4'(WAIT_CYCLES);
`endif

    // In IDLE the live request is decoded so a zero-wait transfer can load readdata on acceptance.
    assign a_addr   = (state == ST_IDLE) ? bus.address[31:2] : lat_addr;
    assign a_be     = (state == ST_IDLE) ? bus.byteenable    : lat_be;
    assign word_idx = a_addr - BASE_ADDR[31:2];
    assign is_halt  = (a_addr == HALT_ADDR[31:2]);
    assign in_range = !is_halt && ({2'b00, word_idx} < 32'(DEPTH_WORDS));
    assign mem_word = in_range ? mem[word_idx[AW-1:0]] : 32'h0;
    assign mask     = lane_mask(a_be);

    assign go_ack = (accept && (wait_val == 4'd0)) ||
                    ((state == ST_WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            lat_addr <= 30'h0;
            lat_wr   <= 1'b0;
            lat_wd   <= 32'h0;
            lat_be   <= 4'h0;
            rdata_q  <= 32'h0;
            berr_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        assert (!(bus.read && bus.write))
                            else $error("read and write asserted together; treated as write");
                        lat_addr <= bus.address[31:2];
                        lat_wr   <= bus.write;
                        lat_wd   <= bus.writedata;
                        lat_be   <= bus.byteenable;
                        if (wait_val == 4'd0) begin
                            state <= ST_ACK;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= wait_val - 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    state  <= ST_IDLE;
                    berr_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (go_ack) begin
                rdata_q <= mem_word & mask;
                berr_q  <= !in_range && !is_halt;
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] = 32'h0;
        end
    end

    // Read-modify-write commit on the edge that ends ACK; a reset in ACK drops it.
    always @(posedge clk) begin
        if (!reset && (state == ST_ACK) && lat_wr && in_range) begin
            mem[word_idx[AW-1:0]] <= (mem_word & ~mask) | (lat_wd & mask);
        end
    end

    assign bus.waitrequest = (state != ST_ACK);
    assign bus.readdata    = rdata_q;
    assign bus.bus_error   = berr_q;

endmodule

// File: tb/tb_mips_cpu_ram_avalon_wait.sv
// Directed bench for mips_cpu_ram_avalon_wait (16-word RAM at 0xBFC00000).
module tb_mips_cpu_ram_avalon_wait;

`ifdef RAM_RANDOM_WAIT_EN
    localparam int TB_WAIT = 3;
`else
    localparam int TB_WAIT = 2;
`endif
    localparam logic [15:0] TB_SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_cpu_ram_avalon_wait_if bus ();

    mips_cpu_ram_avalon_wait #(
        .RAM_INIT_FILE (""),
        .BASE_ADDR     (32'hBFC00000),
        .DEPTH_WORDS   (16),
        .WAIT_CYCLES   (TB_WAIT),
        .LFSR_SEED     (TB_SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] lfsr_m = TB_SEED;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Wait count the DUT should use for the next accepted request.
    function automatic int next_wait();
        int w;
`ifdef RAM_RANDOM_WAIT_EN
        w = int'(lfsr_m[3:0]) % (TB_WAIT + 1);
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
        w = TB_WAIT;
`endif
        return w;
    endfunction

    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output logic berr, output int lat);
        int w;
        w = next_wait();
        @(negedge clk);
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = addr;
        bus.writedata  = wd;
        bus.byteenable = be;
        lat   = 0;
        rdata = 32'h0;
        berr  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!bus.waitrequest) begin
                lat   = i;
                rdata = bus.readdata;
                berr  = bus.bus_error;
                break;
            end
        end
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.address   = 32'hFFFF_FFF0;
        bus.writedata = 32'h0;
        check({tag, "_lat"}, 32'(lat), 32'(1 + w));
        @(negedge clk);
        check({tag, "_ack1"}, {31'h0, bus.waitrequest}, 32'h1);
        check({tag, "_berr_lo"}, {31'h0, bus.bus_error}, 32'h0);
        check({tag, "_hold"}, bus.readdata, rdata);
    endtask

    task automatic rd_word(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] exp_data, input logic exp_berr);
        logic [31:0] d;
        logic        e;
        int          l;
        xfer(tag, 1'b1, 1'b0, addr, 32'h0, be, d, e, l);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_berr"}, {31'h0, e}, {31'h0, exp_berr});
    endtask

    task automatic wr_word(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic exp_berr);
        logic [31:0] d;
        logic        e;
        int          l;
        xfer(tag, 1'b0, 1'b1, addr, wd, be, d, e, l);
        check({tag, "_berr"}, {31'h0, e}, {31'h0, exp_berr});
    endtask

    // Start a write to 0xBFC0000C, reset it in WAIT (at_ack=0) or in ACK (at_ack=1).
    task automatic reset_mid_write(input string tag, input logic at_ack);
        int  w;
        logic seen;
        w = next_wait();
        @(negedge clk);
        bus.write      = 1'b1;
        bus.address    = 32'hBFC0000C;
        bus.writedata  = 32'h77777777;
        bus.byteenable = 4'hF;
        seen = 1'b0;
        if (at_ack) begin
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (!bus.waitrequest) begin
                    seen = 1'b1;
                    break;
                end
            end
            check({tag, "_reached_ack"}, {31'h0, seen}, 32'h1);
        end else begin
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check({tag, "_wreq"}, {31'h0, bus.waitrequest}, 32'h1);
        check({tag, "_rdata"}, bus.readdata, 32'h0);
        lfsr_m = TB_SEED;
        bus.write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {31'h0, bus.waitrequest}, 32'h1);
    endtask

    initial begin
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 32'h0;
        bus.writedata  = 32'h0;
        bus.byteenable = 4'h0;
        reset = 1'b1;
        #12;
        check("rst_wreq", {31'h0, bus.waitrequest}, 32'h1);
        check("rst_rdata", bus.readdata, 32'h0);
        check("rst_berr", {31'h0, bus.bus_error}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic fill and full-word read.
        wr_word("w0",  32'hBFC00000, 32'hCAFEF00D, 4'hF, 1'b0);
        wr_word("w1",  32'hBFC00004, 32'h11223344, 4'hF, 1'b0);
        rd_word("r1",  32'hBFC00004, 4'hF, 32'h11223344, 1'b0);

        // Byte-lane merge on write, lane masking on read.
        wr_word("w2",  32'hBFC00008, 32'h11111111, 4'hF, 1'b0);
        wr_word("w2b", 32'hBFC00008, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd_word("r2",  32'hBFC00008, 4'hF, 32'h11BB11DD, 1'b0);
        rd_word("r2m", 32'hBFC00008, 4'b0011, 32'h000011DD, 1'b0);
        rd_word("r2h", 32'hBFC0000A, 4'b1100, 32'h11BB0000, 1'b0);

        // Halt vector: reads zero, writes ignored, no bus error.
        rd_word("rh",  32'h00000000, 4'hF, 32'h0, 1'b0);
        wr_word("wh",  32'h00000000, 32'hDEADBEEF, 4'hF, 1'b0);
        rd_word("rh0", 32'hBFC00000, 4'hF, 32'hCAFEF00D, 1'b0);

        // One past the end and far away: bus error, no aliasing into word 0.
        rd_word("rob", 32'hBFC00040, 4'hF, 32'h0, 1'b1);
        wr_word("wob", 32'hBFC00040, 32'h12345678, 4'hF, 1'b1);
        rd_word("rob0", 32'hBFC00000, 4'hF, 32'hCAFEF00D, 1'b0);
        rd_word("rlo", 32'hBFBFFFFC, 4'hF, 32'h0, 1'b1);
        rd_word("rlast", 32'hBFC0003C, 4'hF, 32'h0, 1'b0);

        // Reset aborts a pending write in WAIT and in ACK.
        wr_word("w3",  32'hBFC0000C, 32'h5A5A5A5A, 4'hF, 1'b0);
        reset_mid_write("rstw", 1'b0);
        rd_word("r3a", 32'hBFC0000C, 4'hF, 32'h5A5A5A5A, 1'b0);
        reset_mid_write("rsta", 1'b1);
        rd_word("r3b", 32'hBFC0000C, 4'hF, 32'h5A5A5A5A, 1'b0);

`ifdef RAM_RANDOM_WAIT_EN
        begin
            int hist [4];
            int seq [200];
            logic [31:0] d;
            logic        e;
            int          l;
            for (int i = 0; i < 4; i++) hist[i] = 0;
            @(negedge clk);
            reset = 1'b1;
            lfsr_m = TB_SEED;
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 200; i++) begin
                xfer("rnd", 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, d, e, l);
                seq[i] = l;
                if (l >= 1 && l <= 4) hist[l-1]++;
            end
            for (int i = 0; i < 4; i++) begin
                check("rnd_seen", {31'h0, hist[i] > 0}, 32'h1);
            end
            @(negedge clk);
            reset = 1'b1;
            lfsr_m = TB_SEED;
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 200; i++) begin
                xfer("rep", 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'hF, d, e, l);
                check("rep_seq", 32'(l), 32'(seq[i]));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
